// File: rtl/mem_stage.sv
// MEM pipeline stage: req/gnt/rvalid data-memory port, load/store lane handling, pipe stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN (adds misalign_o).
module mem_stage #(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      opfunc3_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic            bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(RESP_TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_we_q, rd_we_d;
  logic              bus_err_q, bus_err_d;
  logic              access_s;
  logic              misalign_s;
  logic [1:0]        off_s;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h00_0000, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0000, h};
      default: fmt_load = w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_be = 4'b0001 << off;
      3'b001:  store_be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  store_wdata = {4{d[7:0]}};
      3'b001:  store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  assign off_s       = mem_addr_i[1:0];
  assign access_s    = mem_re_i | mem_we_i;
  assign dmem_addr_o = {mem_addr_i[XLEN-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Misalignment only applies to half/word sizes; 101 is LHU only for loads.
  always_comb begin
    misalign_s = 1'b0;
    case (opfunc3_i)
      3'b001:  misalign_s = off_s[0];
      3'b101:  misalign_s = ~mem_we_i & off_s[0];
      3'b010:  misalign_s = |off_s;
      default: misalign_s = 1'b0;
    endcase
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_s = 1'b0;
`endif

  always_comb begin
    dmem_be_o    = mem_we_i ? store_be(opfunc3_i, off_s) : 4'b1111;
    dmem_wdata_o = store_wdata(rd_data_i, opfunc3_i);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    stall_o    = 1'b0;
    rd_addr_d  = rd_addr_i;
    rd_data_d  = rd_data_i;
    rd_we_d    = rd_we_i;
    bus_err_d  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (access_s && misalign_s) begin
          rd_we_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b1;
`endif
        end else if (access_s) begin
          dmem_req_o = 1'b1;
          dmem_we_o  = mem_we_i;
          if (dmem_gnt_i && mem_we_i) begin
            rd_we_d = 1'b0;
          end else begin
            // Granted load waits for rvalid; ungranted access keeps requesting.
            if (dmem_gnt_i) begin
              state_d = WAIT_RESP;
            end else begin
              state_d = IDLE;
            end
            stall_o   = 1'b1;
            rd_we_d   = 1'b0;
            rd_addr_d = 5'd0;
            rd_data_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RESP: begin
        // rvalid is checked first so it wins over a coincident timeout.
        if (dmem_rvalid_i) begin
          rd_data_d = fmt_load(dmem_rdata_i, opfunc3_i, off_s);
          state_d   = IDLE;
          cnt_d     = 8'd0;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          bus_err_d = 1'b1;
          rd_we_d   = 1'b0;
          state_d   = IDLE;
          cnt_d     = 8'd0;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          stall_o   = 1'b1;
          rd_we_d   = 1'b0;
          rd_addr_d = 5'd0;
          rd_data_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        rd_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rd_addr_q <= 5'd0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_we_q   <= rd_we_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign rd_we_o   = rd_we_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops against a transaction-level model.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage;
  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_we_i;
  logic [31:0] mem_addr_i;
  logic        mem_re_i, mem_we_i;
  logic [2:0]  opfunc3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o, bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  mem_stage #(.XLEN(32), .RESP_TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_we_i(rd_we_i),
    .mem_addr_i(mem_addr_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .opfunc3_i(opfunc3_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
    .bus_err_o(bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] byte_v, half_v;
    byte_v = (w >> (8 * int'(off))) & 32'h0000_00FF;
    half_v = (w >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
    if (f3 == 3'd0) return (byte_v >= 32'd128) ? (byte_v | 32'hFFFF_FF00) : byte_v;
    if (f3 == 3'd4) return byte_v;
    if (f3 == 3'd1) return (half_v >= 32'd32768) ? (half_v | 32'hFFFF_0000) : half_v;
    if (f3 == 3'd5) return half_v;
    return w;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0) return 32'(1 << int'(off));
    if (f3 == 3'd1) return (off >= 2'd2) ? 32'hC : 32'h3;
    if (f3 == 3'd2) return 32'hF;
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic model_misalign(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
`ifdef MEM_MISALIGN_TRAP_EN
    int o;
    o = int'(off);
    if (f3 == 3'd1 || (f3 == 3'd5 && !we)) return (o % 2) != 0;
    if (f3 == 3'd2) return o != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_in(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic rwe,
                        input logic [2:0] f3);
    mem_re_i = re; mem_we_i = we; mem_addr_i = addr; rd_data_i = data;
    rd_addr_i = rd; rd_we_i = rwe; opfunc3_i = f3;
  endtask

  // gd: cycles before gnt; k: WAIT_RESP cycle on which rvalid arrives (k > T means never).
  task automatic run_op(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic rwe,
                        input logic [2:0] f3, input int gd, input int k, input logic [31:0] rdata);
    logic access, is_st, mis, tmo, live;
    int done;
    access = re | we;
    is_st  = we;
    mis    = access && model_misalign(we, f3, addr[1:0]);
    live   = access && !mis;
    tmo    = 1'b0;
    done   = 0;
    if (live) begin
      if (is_st) done = gd;
      else begin
        tmo  = (k > T);
        done = gd + (tmo ? T : k);
      end
    end
    for (int c = 0; c <= done; c++) begin
      @(negedge clk_i);
      rst_i = 1'b1;
      set_in(re, we, addr, data, rd, rwe, f3);
      dmem_gnt_i   = live && (c == gd);
      dmem_rdata_i = rdata;
      if (!access) dmem_rvalid_i = 1'($urandom_range(0, 1));
      else         dmem_rvalid_i = live && !is_st && (c == gd + k);
      #1;
      chk("stall", 32'(stall_o), 32'(c < done));
      chk("req", 32'(dmem_req_o), 32'(live && c <= gd));
      if (live && c <= gd) begin
        chk("addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
        chk("we", 32'(dmem_we_o), 32'(is_st));
        chk("be", 32'(dmem_be_o), is_st ? model_be(f3, addr[1:0]) : 32'hF);
        if (is_st && f3 <= 3'd2) chk("wdata", dmem_wdata_o, model_wdata(data, f3));
      end
      @(posedge clk_i);
      #1;
      if (c < done) begin
        chk("bubble_we", 32'(rd_we_o), 32'd0);
        chk("bubble_rd", 32'(rd_addr_o), 32'd0);
        chk("bus_err_idle", 32'(bus_err_o), 32'd0);
      end else begin
        chk("bus_err", 32'(bus_err_o), 32'(tmo));
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign", 32'(misalign_o), 32'(mis));
`endif
        if (!access || (live && !is_st && !tmo)) begin
          chk("wb_we", 32'(rd_we_o), 32'(rwe));
          chk("wb_rd", 32'(rd_addr_o), 32'(rd));
          chk("wb_data", rd_data_o, access ? model_load(rdata, f3, addr[1:0]) : data);
        end else begin
          chk("wb_we_kill", 32'(rd_we_o), 32'd0);
        end
      end
    end
  endtask

  initial begin
    int kind;
    logic re, we;
    rst_i = 1'b0;
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    set_in(1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111, 5'd3, 1'b1, 3'd2);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_we", 32'(rd_we_o), 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_mis", 32'(misalign_o), 32'd0);
`endif

    run_op(1'b0, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 3'd0, 0, 1, 32'h0);
    run_op(1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3'd0, 0, 3, 32'h80FF_0000);
    run_op(1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3'd4, 0, 3, 32'h80FF_0000);
    run_op(1'b0, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd2, 1'b1, 3'd1, 3, 1, 32'h0);
    run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 3'd2, 1, 100, 32'h1234_5678);
    run_op(1'b0, 1'b0, 32'h0, 32'h0000_00AA, 5'd1, 1'b1, 3'd0, 0, 1, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd4, 1'b1, 3'd5, 0, T, 32'hABCD_8765);
    run_op(1'b1, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 1'b1, 3'd2, 0, 1, 32'h0BAD_F00D);
    run_op(1'b1, 1'b1, 32'h0000_0301, 32'h0000_00C3, 5'd6, 1'b1, 3'd0, 1, 1, 32'h0);

    // Reset while a load is in flight; the later rvalid in IDLE must be ignored.
    @(negedge clk_i);
    set_in(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd4, 1'b1, 3'd2);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst_we", 32'(rd_we_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0000_CAFE, 5'd6, 1'b1, 3'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("midrst_data", rd_data_o, 32'h0000_CAFE);
    chk("midrst_wb_we", 32'(rd_we_o), 32'd1);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      re = (kind == 1) || (kind == 3);
      we = (kind == 2) || (kind == 3);
      run_op(re, we, $urandom, $urandom, 5'($urandom), 1'($urandom), 3'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage; sits between the execute stage and writeback.
- Consumes the execute stage's registered outputs: rd_addr, rd_data, rd_we, mem_addr, mem_re, mem_we and opfunc3.
- Drives a req/gnt/rvalid data-memory port, handling byte lanes, load sign/zero extension and store lane replication.
- Stalls the pipe through pipectrl while an access is outstanding.
- Passes non-memory results to writeback with one-cycle latency.

Parameters:
XLEN, 32, data/address width; RV32 only, so byte enables are fixed at 4 bits.
RESP_TIMEOUT, 255, max cycles in WAIT_RESP before a bus error is declared; 8-bit counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
rd_addr_i  in  5  destination register from execute
rd_data_i  in  XLEN  ALU result; store data when mem_we_i=1
rd_we_i  in  1  register write enable from execute
mem_addr_i  in  XLEN  effective address from execute
mem_re_i  in  1  load
mem_we_i  in  1  store
opfunc3_i  in  3  load/store size and sign
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  XLEN  word-aligned address ({mem_addr_i[XLEN-1:2],2'b00})
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_be_o  out  4  byte enables
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
stall_o  out  1  to pipectrl: freeze execute and upstream stages
rd_addr_o  out  5  to writeback
rd_data_o  out  XLEN  to writeback
rd_we_o  out  1  to writeback
bus_err_o  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset (rst_i=0 at a posedge clk_i):
  - Registered outputs rd_addr_o, rd_data_o, rd_we_o, bus_err_o and misalign_o go to 0.
  - State returns to IDLE; timeout counter cleared.
  - An in-flight access is abandoned; any dmem_rvalid_i arriving later while in IDLE is ignored.
- access = mem_re_i | mem_we_i. If both are set, the access is a store.
- Non-access cycle:
  - Output register loads rd_addr_i, rd_data_i and rd_we_i; one-cycle latency.
  - stall_o=0.
- FSM states: IDLE, WAIT_RESP.
- IDLE with access:
  - dmem_req_o=1 combinationally; dmem_we_o=mem_we_i.
  - Store with gnt=1: access completes this cycle. stall_o=0; output register gets rd_we_o=0.
  - Load with gnt=1: go to WAIT_RESP; stall_o=1.
  - gnt=0: stay in IDLE, keep request asserted; stall_o=1.
- WAIT_RESP:
  - dmem_req_o=0; counter increments each cycle.
  - On rvalid=1: stall_o=0; output register gets rd_addr_i, the formatted load data and rd_we_i; go to IDLE; counter cleared.
  - If the counter reaches RESP_TIMEOUT without rvalid: bus_err_o pulses; output gets rd_we_o=0; stall_o=0; go to IDLE.
  - rvalid on the same cycle as the timeout: rvalid wins and no error is raised.
- While stall_o=1:
  - Output register holds a bubble (rd_we_o=0, rd_addr_o=0).
  - pipectrl keeps all *_i inputs stable.
- stall_o = access & !(completion this cycle).
- Load format (off = mem_addr_i[1:0]):
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW: full word.
  - Other funct3 values: full word.
- Store format:
  - 000 SB: be=4'b0001<<off; wdata={4{rd_data_i[7:0]}}.
  - 001 SH: be=off[1]?4'b1100:4'b0011; wdata={2{rd_data_i[15:0]}}.
  - 010 SW: be=4'b1111; wdata=rd_data_i.
  - Others: be=0 and the request is still issued.
- Without the optional feature, misaligned low address bits are ignored as given above.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misalign_o (1 bit, registered).
  - An LH/LHU/SH with off[0]=1, or an LW/SW with off!=0, issues no request and does not stall.
  - For that access: misalign_o pulses for 1 cycle; output gets rd_we_o=0.
- When undefined: port absent; misaligned accesses proceed with the truncation rules above.

Test Plan:
- Reset: hold rst_i=0 with mem_re_i=1 and gnt=1 -> dmem_req_o ignored, all registered outputs 0, state IDLE.
- ALU passthrough: rd_addr_i=5, rd_data_i=0x1234, rd_we_i=1 -> next cycle rd_addr_o=5, rd_data_o=0x1234, rd_we_o=1; stall_o never asserted.
- LB at addr 0x103, rdata=0x80FF_0000, gnt immediate, rvalid 2 cycles later -> stall_o high 3 cycles, then rd_data_o=0xFFFF_FF80; LBU of the same access -> 0x0000_0080.
- SH at 0x202 with rd_data_i=0xDEAD_BEEF, gnt delayed 3 cycles -> dmem_be_o=4'b1100, dmem_wdata_o=0xBEEF_BEEF, dmem_addr_o=0x200, stall_o high 3 cycles, rd_we_o=0.
- Load with no rvalid and RESP_TIMEOUT=4 -> bus_err_o pulse after 4 WAIT_RESP cycles, stall released, rd_we_o=0; a late rvalid is ignored.
- MEM_MISALIGN_TRAP_EN defined, LW at 0x101 -> no dmem_req_o, misalign_o=1 for 1 cycle, rd_we_o=0; with the macro undefined -> request to 0x100 with be=4'b1111.
